// File: rtl/al422_bam_row_sequencer.sv
// rtl/al422_bam_row_sequencer.sv - BAM plane/row scan sequencer for an AL422-fed LED panel
module al422_bam_row_sequencer #(
  parameter int ROWS        = 16,
  parameter int PLANES      = 8,
  parameter int OE_BASE     = 1,
  parameter int LATCH_WIDTH = 2
) (
  input  logic                    in_clk,
  input  logic                    in_nrst,
  input  logic                    frame_start,
  output logic                    shift_start,
  input  logic                    shift_busy,
  output logic                    oe_start,
  input  logic                    oe_busy,
  output logic [7:0]              oe_duration,
  output logic                    led_lat,
  output logic [$clog2(ROWS)-1:0] row_addr,
  output logic                    frame_busy,
  output logic                    frame_done
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int LAT_W   = (LATCH_WIDTH > 1) ? $clog2(LATCH_WIDTH) : 1;

  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(PLANES - 1);
  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(LATCH_WIDTH - 1);
  localparam logic [7:0]         DUR_RESET  = (OE_BASE > 255) ? 8'd255 : 8'(OE_BASE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WAIT  = 3'd2,
    LATCH = 3'd3,
    FIRE  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t state;
  state_t state_d;

  // shift_first marks the SHIFT cycle carrying the shift_start pulse; shift_busy is not yet valid then
  logic               shift_first;
  logic [PLANE_W-1:0] plane_cnt;      // pending plane (next to latch)
  logic [ROW_W-1:0]   row_cnt;        // pending row (next to latch)
  logic [PLANE_W-1:0] latched_plane;  // plane currently on the panel
  logic [LAT_W-1:0]   lat_cnt;
  logic               done_q;
  logic               last_unit;

  // Binary-weighted OE length, saturated to the 8-bit output range
  function automatic logic [7:0] plane_duration(input logic [PLANE_W-1:0] plane);
    logic [39:0] scaled;
    scaled = 40'(OE_BASE) << plane;
    if (scaled > 40'd255) begin
      return 8'd255;
    end
    return scaled[7:0];
  endfunction

  assign last_unit = (latched_plane == LAST_PLANE) && (row_addr == LAST_ROW);

  // State register
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (frame_start) state_d = SHIFT;
      SHIFT:   if (!shift_first && !shift_busy) state_d = WAIT;
      WAIT:    if (!oe_busy) state_d = LATCH;
      LATCH:   if (lat_cnt == LAT_LAST) state_d = FIRE;
      FIRE:    state_d = last_unit ? DRAIN : SHIFT;
      DRAIN:   if (!oe_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    shift_start = (state == SHIFT) && shift_first;
    led_lat     = (state == LATCH);
    oe_start    = (state == FIRE);
    frame_busy  = (state != IDLE);
    frame_done  = done_q;
  end

  // Counters, latched row/plane and OE length, updated on state transitions
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      shift_first   <= 1'b0;
      plane_cnt     <= '0;
      row_cnt       <= '0;
      latched_plane <= '0;
      lat_cnt       <= '0;
      row_addr      <= '0;
      oe_duration   <= DUR_RESET;
      done_q        <= 1'b0;
    end else begin
      shift_first <= (state_d == SHIFT) && (state != SHIFT);
      done_q      <= (state == DRAIN) && (state_d == IDLE);
      case (state)
        IDLE: begin
          if (frame_start) begin
            plane_cnt <= '0;
            row_cnt   <= '0;
          end
        end
        WAIT: begin
          if (state_d == LATCH) begin
            row_addr      <= row_cnt;
            latched_plane <= plane_cnt;
            lat_cnt       <= '0;
          end
        end
        LATCH: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (state_d == FIRE) begin
            oe_duration <= plane_duration(latched_plane);
          end
        end
        FIRE: begin
          // Advance the pending unit so the next plane shifts during this OE period
          if (state_d == SHIFT) begin
            if (plane_cnt == LAST_PLANE) begin
              plane_cnt <= '0;
              row_cnt   <= row_cnt + 1'b1;
            end else begin
              plane_cnt <= plane_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_al422_bam_row_sequencer.sv
// tb/tb_al422_bam_row_sequencer.sv - self-checking bench for al422_bam_row_sequencer
module tb_al422_bam_row_sequencer;

  localparam int ROWS    = 2;
  localparam int PLANES  = 8;
  localparam int OE_BASE = 3;
  localparam int LW      = 2;
  localparam int RW      = $clog2(ROWS);
  localparam int N       = ROWS * PLANES;

  logic          in_clk = 1'b0;
  logic          in_nrst = 1'b0;
  logic          frame_start = 1'b0;
  logic          shift_busy = 1'b0;
  logic          oe_busy = 1'b0;
  logic          shift_start;
  logic          oe_start;
  logic [7:0]    oe_duration;
  logic          led_lat;
  logic [RW-1:0] row_addr;
  logic          frame_busy;
  logic          frame_done;

  al422_bam_row_sequencer #(
    .ROWS(ROWS), .PLANES(PLANES), .OE_BASE(OE_BASE), .LATCH_WIDTH(LW)
  ) dut (
    .in_clk(in_clk), .in_nrst(in_nrst), .frame_start(frame_start),
    .shift_start(shift_start), .shift_busy(shift_busy),
    .oe_start(oe_start), .oe_busy(oe_busy), .oe_duration(oe_duration),
    .led_lat(led_lat), .row_addr(row_addr),
    .frame_busy(frame_busy), .frame_done(frame_done)
  );

  always #5 in_clk = ~in_clk;

  int total = 0;
  int bad = 0;
  int shown = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (shown < 40) $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
      shown++;
    end
  endtask

  function automatic int dur(input int p);
    int v;
    v = OE_BASE << p;
    return (v > 255) ? 255 : v;
  endfunction

  // Environment: shifter and OE processor, each busy for a set number of cycles
  int   shift_len = 1;
  int   oe_len = 1;
  int   sh_cnt = 0;
  int   oe_cnt = 0;
  logic prev_sh = 1'b0;
  logic prev_oe = 1'b0;

  initial forever begin
    @(posedge in_clk);
    #1;
    if (sh_cnt > 0) sh_cnt--;
    if (oe_cnt > 0) oe_cnt--;
    if (prev_sh) sh_cnt = shift_len;
    if (prev_oe) oe_cnt = oe_len;
    shift_busy = (sh_cnt > 0);
    oe_busy    = (oe_cnt > 0);
    prev_sh    = shift_start;
    prev_oe    = oe_start;
  end

  // Timing model: each output pulse is scheduled from frame_start and the busy inputs
  int   active = 0, idx = 0;
  int   busy_from = 0, busy_until = 0;
  int   shift_due = -1, shift_free = -1;
  int   lat_sched = 0, lat_rise = -100, oe_due = -1;
  int   drain_from = -1, done_sched = 0, done_due = -1;
  logic fire_row1 = 1'b0;
  logic exp_shift, exp_lat, exp_oe, exp_done, exp_busy;

  // Observation logs
  logic [7:0] ev[$];
  int         dq[$];
  int         rq[$];
  int         gaps[$];
  int         done_cnt = 0;
  int         last_oe_cyc = 0;
  int         have_oe = 0;
  logic       prev_lat = 1'b0;

  initial forever begin
    @(negedge in_clk);
    cyc++;
    if (!in_nrst) begin
      active = 0; busy_from = 0; busy_until = 0;
      shift_due = -1; shift_free = -1; lat_sched = 0; lat_rise = -100; oe_due = -1;
      drain_from = -1; done_sched = 0; done_due = -1;
      fire_row1 = 1'b0; prev_lat = 1'b0;
    end else begin
      exp_shift = (cyc == shift_due);
      exp_lat   = (lat_sched != 0) && (cyc >= lat_rise) && (cyc < lat_rise + LW);
      exp_oe    = (cyc == oe_due);
      exp_done  = (cyc == done_due);
      exp_busy  = (cyc >= busy_from) && (cyc < busy_until);
      fire_row1 = exp_oe && (idx / PLANES == 1);

      chk("shift_start", shift_start, exp_shift);
      chk("led_lat", led_lat, exp_lat);
      chk("oe_start", oe_start, exp_oe);
      chk("frame_done", frame_done, exp_done);
      chk("frame_busy", frame_busy, exp_busy);
      chk("shift_oe_overlap", shift_start && oe_start, 0);
      chk("lat_while_oe_busy", led_lat && oe_busy, 0);
      chk("oe_dur_nonzero", oe_duration != 8'd0, 1);
      if (lat_sched != 0 && cyc == lat_rise) chk("latch_row", row_addr, idx / PLANES);
      if (exp_oe) chk("oe_duration", oe_duration, dur(idx % PLANES));

      if (shift_start) ev.push_back("S");
      if (led_lat && !prev_lat) begin
        ev.push_back("L");
        rq.push_back(int'(row_addr));
        if (have_oe != 0) gaps.push_back(cyc - last_oe_cyc);
      end
      if (oe_start) begin
        ev.push_back("O");
        dq.push_back(int'(oe_duration));
        last_oe_cyc = cyc;
        have_oe = 1;
      end
      if (frame_done) begin
        ev.push_back("D");
        done_cnt++;
      end
      prev_lat = led_lat;

      if (cyc == done_due) active = 0;
      if (active == 0 && frame_start) begin
        active = 1; idx = 0;
        busy_from = cyc + 1; busy_until = 1 << 30;
        shift_due = cyc + 1; shift_free = -1; lat_sched = 0;
        drain_from = -1; done_sched = 0;
      end
      if (active != 0) begin
        if (shift_free < 0 && shift_due >= 0 && cyc > shift_due && !shift_busy) shift_free = cyc;
        if (shift_free >= 0 && lat_sched == 0 && cyc > shift_free && !oe_busy) begin
          lat_sched = 1;
          lat_rise  = cyc + 1;
          oe_due    = cyc + 1 + LW;
        end
        if (cyc == oe_due) begin
          if (idx == N - 1) begin
            drain_from = cyc + 1;
          end else begin
            idx++;
            shift_due = cyc + 1; shift_free = -1; lat_sched = 0;
          end
        end
        if (drain_from >= 0 && done_sched == 0 && cyc >= drain_from && !oe_busy) begin
          done_sched = 1;
          done_due   = cyc + 1;
          busy_until = cyc + 1;
        end
      end
    end
  end

  task automatic clear_logs();
    ev.delete(); dq.delete(); rq.delete(); gaps.delete();
    have_oe = 0;
  endtask

  task automatic pulse_start();
    @(posedge in_clk); #2; frame_start = 1'b1;
    @(posedge in_clk); #2; frame_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge in_clk); #3;
      n++;
    end
    chk(nm, done_cnt != start, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge in_clk);
    #3;
  endtask

  int exp_d[8] = '{3, 6, 12, 24, 48, 96, 192, 255};
  int d0;
  int n;

  initial begin
    // Reset values while in_nrst is low
    #22;
    chk("rst_shift_start", shift_start, 0);
    chk("rst_oe_start", oe_start, 0);
    chk("rst_led_lat", led_lat, 0);
    chk("rst_frame_busy", frame_busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_row_addr", row_addr, 0);
    chk("rst_oe_duration", oe_duration, 3);
    @(negedge in_clk); #2; in_nrst = 1'b1;
    idle_cycles(3);

    // Instant shifter and OE processor: full frame, literal order and durations
    shift_len = 1; oe_len = 1;
    clear_logs();
    pulse_start();
    wait_done("t_fast_done", 3000);
    chk("t_fast_events", ev.size(), 49);
    chk("t_fast_ev0", (ev.size() > 0) ? ev[0] : 8'd0, "S");
    chk("t_fast_ev1", (ev.size() > 1) ? ev[1] : 8'd0, "L");
    chk("t_fast_ev2", (ev.size() > 2) ? ev[2] : 8'd0, "O");
    chk("t_fast_ev3", (ev.size() > 3) ? ev[3] : 8'd0, "S");
    chk("t_fast_ev48", (ev.size() > 48) ? ev[48] : 8'd0, "D");
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t_fast_dur%0d", i), (i < dq.size()) ? dq[i] : 999, exp_d[i % 8]);
      chk($sformatf("t_fast_row%0d", i), (i < rq.size()) ? rq[i] : 999, (i < 8) ? 0 : 1);
    end
    chk("t_fast_gap", (gaps.size() > 0) ? gaps[0] : 0, 5);
    idle_cycles(4);

    // Slow OE processor: latch only after oe_busy falls
    shift_len = 5; oe_len = 50;
    clear_logs();
    pulse_start();
    wait_done("t_slow_done", 5000);
    chk("t_slow_gaps", gaps.size(), 15);
    chk("t_slow_gap0", (gaps.size() > 0) ? gaps[0] : 0, 52);
    idle_cycles(4);

    // shift_busy and oe_busy fall together
    shift_len = 5; oe_len = 6;
    clear_logs();
    pulse_start();
    wait_done("t_same_done", 3000);
    chk("t_same_gap0", (gaps.size() > 0) ? gaps[0] : 0, 9);
    chk("t_same_gap14", (gaps.size() > 14) ? gaps[14] : 0, 9);
    idle_cycles(4);

    // frame_start repeated mid-frame is ignored
    shift_len = 2; oe_len = 3;
    clear_logs();
    d0 = done_cnt;
    pulse_start();
    idle_cycles(10);
    pulse_start();
    idle_cycles(20);
    pulse_start();
    wait_done("t_ignore_done", 3000);
    idle_cycles(30);
    chk("t_ignore_done_count", done_cnt - d0, 1);
    chk("t_ignore_events", ev.size(), 49);

    // Reset during FIRE of row 1 aborts the frame
    shift_len = 2; oe_len = 4;
    clear_logs();
    pulse_start();
    n = 0;
    do begin
      @(negedge in_clk); #2;
      n++;
    end while (!fire_row1 && n < 3000);
    chk("t_rst_found_fire", fire_row1, 1);
    chk("t_rst_fire_oe", oe_start, 1);
    in_nrst = 1'b0;
    #1;
    chk("t_rst_shift_start", shift_start, 0);
    chk("t_rst_oe_start", oe_start, 0);
    chk("t_rst_led_lat", led_lat, 0);
    chk("t_rst_frame_busy", frame_busy, 0);
    chk("t_rst_frame_done", frame_done, 0);
    chk("t_rst_row_addr", row_addr, 0);
    chk("t_rst_oe_duration", oe_duration, 3);
    d0 = done_cnt;
    repeat (3) @(negedge in_clk);
    #2; in_nrst = 1'b1;
    idle_cycles(10);
    chk("t_rst_no_done", done_cnt - d0, 0);
    clear_logs();
    pulse_start();
    wait_done("t_rst_restart_done", 3000);
    chk("t_rst_first_row", (rq.size() > 0) ? rq[0] : 999, 0);
    chk("t_rst_first_dur", (dq.size() > 0) ? dq[0] : 999, 3);
    chk("t_rst_events", ev.size(), 49);
    idle_cycles(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/al422_bam_row_sequencer.md
AL422_BAM_ROW_SEQUENCER -- requirements
Module: al422_bam_row_sequencer

Interface
REQ-001 Parameter ROWS, default 16: number of panel rows scanned per frame (>=2).
REQ-002 Parameter PLANES, default 8: BAM bit planes per row (1..8).
REQ-003 Parameter OE_BASE, default 1: OE duration units for plane 0 (>=1).
REQ-004 Parameter LATCH_WIDTH, default 2: led_lat high time in clocks (>=1).
REQ-005 in_clk  input  1  sole clock, all logic on rising edge.
REQ-006 in_nrst  input  1  reset, asynchronous, active-low.
REQ-007 frame_start  input  1  one-cycle request to scan one frame.
REQ-008 shift_start  output  1  one-cycle pulse; starts shifting of one plane of row data.
REQ-009 shift_busy  input  1  shifter busy; rises the cycle after shift_start.
REQ-010 oe_start  output  1  one-cycle pulse to the OE processor's module_start.
REQ-011 oe_busy  input  1  OE processor module_is_busy; rises the cycle after oe_start.
REQ-012 oe_duration  output  8  OE length in prescaled units; stable while oe_start is high.
REQ-013 led_lat  output  1  panel latch strobe.
REQ-014 row_addr  output  $clog2(ROWS)  row currently displayed.
REQ-015 frame_busy  output  1  high from accepted frame_start until frame_done.
REQ-016 frame_done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, WAIT, LATCH, FIRE, DRAIN.
REQ-018 IDLE: frame_start=1 SHALL set frame_busy, clear the plane and row counters, pulse shift_start, and go to SHIFT; frame_start outside IDLE SHALL be ignored.
REQ-019 SHIFT: on the cycle after the shift_start pulse, and on each following cycle, shift_busy=0 SHALL move the FSM to WAIT.
REQ-020 WAIT: the FSM SHALL stay until oe_busy=0, then enter LATCH; the data being latched always belongs to the pending plane/row (next_plane, next_row).
REQ-021 LATCH: led_lat SHALL be high for exactly LATCH_WIDTH cycles.
REQ-022 On the first LATCH cycle, row_addr SHALL take next_row.
REQ-023 FIRE: led_lat=0; oe_start SHALL pulse for one cycle with oe_duration = min(OE_BASE << plane, 255), where plane is the plane just latched.
REQ-024 oe_duration SHALL never be 0.
REQ-025 After FIRE, if the latched plane was the last plane (PLANES-1) of the last row (ROWS-1), the FSM SHALL go to DRAIN.
REQ-026 Otherwise, after FIRE the FSM SHALL advance next_plane (wrapping to 0 and incrementing next_row at PLANES-1), pulse shift_start on the cycle after FIRE, and enter SHIFT, so that shifting overlaps the OE period.
REQ-027 DRAIN: on the cycle after FIRE and later, oe_busy=0 SHALL pulse frame_done, clear frame_busy, and return to IDLE.
REQ-028 shift_start and oe_start SHALL never be high in the same cycle.
REQ-029 led_lat SHALL never be high while oe_busy=1.
REQ-030 If shift_busy and oe_busy fall in the same cycle in WAIT, LATCH SHALL follow on the next cycle.

Reset
REQ-031 While in_nrst=0: state IDLE, shift_start=0, oe_start=0, led_lat=0, frame_busy=0, frame_done=0, row_addr=0, oe_duration=OE_BASE (clamped), counters 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_done; the first frame_start after release SHALL begin again at row 0, plane 0.

Verification
REQ-033 ROWS=2, PLANES=2, OE_BASE=3, instant shifter and OE model (busy 1 cycle) -> pulse order shift,lat,oe(3),shift,lat,oe(6),shift,lat,oe(3),shift,lat,oe(6), then frame_done; row_addr 0,0,1,1 at successive latches.
REQ-034 OE model busy 50 cycles, shifter busy 5 -> led_lat rises only after oe_busy falls; zero latches while oe_busy=1.
REQ-035 PLANES=8, OE_BASE=3 -> plane 7 oe_duration=255 (saturated); plane 6 = 192.
REQ-036 frame_start pulsed again mid-frame -> ignored; frame_done count = 1.
REQ-037 in_nrst low during FIRE of row 1 -> all outputs at reset values asynchronously; next frame starts with row_addr=0, oe_duration=OE_BASE.
REQ-038 shift_busy and oe_busy fall on the same edge in WAIT -> led_lat high on the next cycle for LATCH_WIDTH cycles.
